// File: rtl/mem_backing_store.sv
// Block-granular main-memory model behind the cache: services write-backs and
// refills with a fixed, parameterised latency and a ready_mem/acknowledge handshake.
module mem_backing_store #(
  parameter int ADDR_W       = 32,
  parameter int BLOCK_WORDS  = 4,
  parameter int DEPTH_BLOCKS = 256,
  parameter int RD_LAT       = 4,
  parameter int WR_LAT       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_en_mem,
  input  logic                    write_en_mem,
  input  logic [ADDR_W-1:0]       address,
  input  logic [32*BLOCK_WORDS-1:0] dirty_block_in,
  input  logic                    acknowledge,
  output logic [32*BLOCK_WORDS-1:0] block_out,
  output logic                    ready_mem,
  output logic                    busy
);

  localparam int BW    = 32 * BLOCK_WORDS;
  localparam int OFF_W = $clog2(4 * BLOCK_WORDS);
  localparam int IDX_W = $clog2(DEPTH_BLOCKS);
  localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_LOAD = 8'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BW-1:0]    wdata_q, wdata_d;
  logic [BW-1:0]    block_out_q, block_out_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             mem_we_s;
  logic [IDX_W-1:0] index_s;
  logic [BW-1:0]    mem_q [DEPTH_BLOCKS];

  // Offset bits and block-number bits above the array depth alias away.
  logic unused_addr_s;
  assign unused_addr_s = ^{address[OFF_W-1:0], address[ADDR_W-1:OFF_W+IDX_W]};
  assign index_s       = address[OFF_W +: IDX_W];

  // State register and all control/data flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= '0;
      wdata_q     <= '0;
      block_out_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      block_out_q <= block_out_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array; contents survive reset, and a reset edge never commits a write
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (write_en_mem) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LOAD;
        end else if (read_en_mem) begin
          state_d = RD_WAIT;
          cnt_d   = RD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (acknowledge) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Registered outputs, request latches and the array write strobe
  always_comb begin
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    block_out_d = block_out_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    mem_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_en_mem) begin
          idx_d   = index_s;
          wdata_d = dirty_block_in;
          busy_d  = 1'b1;
        end else if (read_en_mem) begin
          idx_d   = index_s;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          ready_d     = 1'b1;
          block_out_d = mem_q[idx_q];
        end else begin
          ready_d     = 1'b0;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 8'd0) begin
          ready_d  = 1'b1;
          mem_we_s = 1'b1;
        end else begin
          ready_d  = 1'b0;
        end
      end
      RESP: begin
        if (acknowledge) begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign block_out = block_out_q;
  assign ready_mem = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_backing_store.sv
// Directed bench for mem_backing_store: default-latency instance (0) and an
// RD_LAT=1 / WR_LAT=7 instance (1) driven from one sequence of scenario tasks.
module tb_mem_backing_store;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en [2];
  logic         wr_en [2];
  logic [31:0]  addr  [2];
  logic [127:0] din   [2];
  logic         ack   [2];
  logic [127:0] bout  [2];
  logic         ready [2];
  logic         busy  [2];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] D_MAIN = 128'h4444_3333_2222_1111_8888_7777_6666_0000;
  localparam logic [127:0] D_AA   = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] D_11   = {4{32'h1111_1111}};
  localparam logic [127:0] D_55   = {4{32'h5555_5555}};
  localparam logic [127:0] D_BEEF = {8{16'hBEEF}};
  localparam logic [127:0] D_LAT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  mem_backing_store dut_a (
    .clk(clk), .rst(rst), .read_en_mem(rd_en[0]), .write_en_mem(wr_en[0]),
    .address(addr[0]), .dirty_block_in(din[0]), .acknowledge(ack[0]),
    .block_out(bout[0]), .ready_mem(ready[0]), .busy(busy[0])
  );

  mem_backing_store #(.RD_LAT(1), .WR_LAT(7)) dut_b (
    .clk(clk), .rst(rst), .read_en_mem(rd_en[1]), .write_en_mem(wr_en[1]),
    .address(addr[1]), .dirty_block_in(din[1]), .acknowledge(ack[1]),
    .block_out(bout[1]), .ready_mem(ready[1]), .busy(busy[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int s, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [127:0] d);
    rd_en[s] = rd;
    wr_en[s] = wr;
    addr[s]  = a;
    din[s]   = d;
    tick();
    rd_en[s] = 1'b0;
    wr_en[s] = 1'b0;
    addr[s]  = 32'hDEAD_BEE0;
    din[s]   = '0;
  endtask

  // Cycles from the acceptance edge until ready_mem is seen; bounded at 40.
  task automatic wait_ready(input int s, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ready[s] !== 1'b1 && lat < 40);
  endtask

  task automatic do_ack(input int s);
    ack[s] = 1'b1;
    tick();
    ack[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (ready[s] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 0", s, ready[s]); end
      n_checks++;
      if (busy[s] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", s, busy[s]); end
      n_checks++;
      if (bout[s] !== 128'd0) begin n_fail++; $display("FAIL reset_block_out[%0d] got %h want 0", s, bout[s]); end
    end
  endtask

  task automatic test_write_read();
    int lat;
    accept(0, 1'b1, 1'b0, 32'h0000_0040, D_MAIN);
    n_checks++;
    if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL wr_busy got %b want 1", busy[0]); end
    wait_ready(0, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL wr_latency got %0d want 4", lat); end
    do_ack(0);
    n_checks++;
    if (ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL wr_ack_release got ready=%b busy=%b want 0 0", ready[0], busy[0]);
    end
    accept(0, 1'b0, 1'b1, 32'h0000_0048, '0);
    wait_ready(0, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL rd_latency got %0d want 4", lat); end
    n_checks++;
    if (bout[0] !== D_MAIN) begin n_fail++; $display("FAIL rd_data got %h want %h", bout[0], D_MAIN); end
    do_ack(0);
  endtask

  task automatic test_simultaneous();
    int lat;
    accept(0, 1'b1, 1'b1, 32'h0000_0080, D_AA);
    n_checks++;
    if (dut_a.state_q !== 2'd2) begin n_fail++; $display("FAIL simul_state got %0d want 2 (WR_WAIT)", dut_a.state_q); end
    wait_ready(0, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL simul_wr_latency got %0d want 4", lat); end
    n_checks++;
    if (bout[0] !== D_MAIN) begin n_fail++; $display("FAIL simul_block_out_held got %h want %h", bout[0], D_MAIN); end
    do_ack(0);
    accept(0, 1'b0, 1'b1, 32'h0000_0080, '0);
    wait_ready(0, lat);
    n_checks++;
    if (bout[0] !== D_AA) begin n_fail++; $display("FAIL simul_reread got %h want %h", bout[0], D_AA); end
    do_ack(0);
  endtask

  task automatic test_delayed_ack();
    int lat;
    accept(0, 1'b0, 1'b1, 32'h0000_0040, '0);
    wait_ready(0, lat);
    for (int i = 0; i < 10; i++) begin
      rd_en[0] = i[0];
      wr_en[0] = ~i[0];
      addr[0]  = 32'h0000_0040;
      din[0]   = D_55;
      tick();
      n_checks++;
      if (ready[0] !== 1'b1 || bout[0] !== D_MAIN) begin
        n_fail++; $display("FAIL hold_cycle%0d got ready=%b data=%h want 1 %h", i, ready[0], bout[0], D_MAIN);
      end
    end
    rd_en[0] = 1'b0;
    wr_en[0] = 1'b0;
    do_ack(0);
    n_checks++;
    if (ready[0] !== 1'b0) begin n_fail++; $display("FAIL hold_ack_drop got %b want 0", ready[0]); end
    accept(0, 1'b0, 1'b1, 32'h0000_0044, '0);
    wait_ready(0, lat);
    n_checks++;
    if (bout[0] !== D_MAIN) begin n_fail++; $display("FAIL hold_ignored_write got %h want %h", bout[0], D_MAIN); end
    do_ack(0);
  endtask

  task automatic test_reset_mid_write();
    int lat;
    accept(0, 1'b1, 1'b0, 32'h0000_0100, D_11);
    wait_ready(0, lat);
    do_ack(0);
    accept(0, 1'b1, 1'b0, 32'h0000_0100, D_55);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got ready=%b busy=%b want 0 0", ready[0], busy[0]);
    end
    accept(0, 1'b0, 1'b1, 32'h0000_0100, '0);
    wait_ready(0, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL rst_mid_rd_latency got %0d want 4", lat); end
    n_checks++;
    if (bout[0] !== D_11) begin n_fail++; $display("FAIL rst_mid_old_data got %h want %h", bout[0], D_11); end
    do_ack(0);
  endtask

  task automatic test_alias();
    int lat;
    accept(0, 1'b1, 1'b0, 32'h0000_0000, D_BEEF);
    wait_ready(0, lat);
    do_ack(0);
    accept(0, 1'b0, 1'b1, 32'h0000_1000, '0);
    wait_ready(0, lat);
    n_checks++;
    if (bout[0] !== D_BEEF) begin n_fail++; $display("FAIL alias_data got %h want %h", bout[0], D_BEEF); end
    do_ack(0);
  endtask

  task automatic test_latency_params();
    int lat;
    accept(1, 1'b1, 1'b0, 32'h0000_0020, D_LAT);
    wait_ready(1, lat);
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL lat_wr7 got %0d want 7", lat); end
    do_ack(1);
    ack[1] = 1'b1;
    tick();
    tick();
    ack[1] = 1'b0;
    n_checks++;
    if (ready[1] !== 1'b0 || busy[1] !== 1'b0 || dut_b.state_q !== 2'd0) begin
      n_fail++; $display("FAIL stray_ack got ready=%b busy=%b state=%0d want 0 0 0", ready[1], busy[1], dut_b.state_q);
    end
    accept(1, 1'b0, 1'b1, 32'h0000_0020, '0);
    wait_ready(1, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL lat_rd1 got %0d want 1", lat); end
    n_checks++;
    if (bout[1] !== D_LAT) begin n_fail++; $display("FAIL lat_rd1_data got %h want %h", bout[1], D_LAT); end
    do_ack(1);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rd_en[s] = 1'b0;
      wr_en[s] = 1'b0;
      addr[s]  = '0;
      din[s]   = '0;
      ack[s]   = 1'b0;
    end
    test_reset();
    test_write_read();
    test_simultaneous();
    test_delayed_ack();
    test_reset_mid_write();
    test_alias();
    test_latency_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
